// File: rtl/panda_seq_table.sv
// Sequencer table store: a writer loads 32-bit words, commits a length, and a
// consumer steps through the stored 4-word frames, one fetch of 4 RAM reads per frame.
module panda_seq_table #(
    parameter int DEPTH_FRAMES = 256
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         TABLE_START,
    input  logic [31:0]  TABLE_DATA,
    input  logic         TABLE_WSTB,
    input  logic [15:0]  TABLE_LENGTH,
    input  logic         TABLE_LENGTH_WSTB,
    input  logic         frame_rd_i,
    input  logic         frame_rst_i,
    output logic [127:0] frame_o,
    output logic         frame_valid_o,
    output logic [15:0]  frame_index_o,
    output logic [15:0]  frame_count_o,
    output logic         table_ready_o,
    output logic         wr_err_o
);
    localparam int FW    = (DEPTH_FRAMES > 1) ? $clog2(DEPTH_FRAMES) : 1;
    localparam int AW    = FW + 2;
    localparam int WORDS = DEPTH_FRAMES * 4;

    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

    logic [31:0]   mem [WORDS];
    logic [31:0]   rd_data_q;
    logic [AW:0]   wptr_q;
    logic [AW-1:0] rd_addr;
    state_t        state_q;
    logic [2:0]    cnt_q;
    logic [FW-1:0] index_q;
    logic [FW:0]   count_q;
    logic          ready_q;
    logic          valid_q;
    logic          err_q;
    logic [31:0]   lane_q [4];

    logic          wr_full;
    logic          wr_en;
    logic          len_ok;
    logic          rst_acc;
    logic          rd_acc;
    logic [FW-1:0] index_inc;

    assign wr_full   = (wptr_q == (AW+1)'(WORDS));
    assign wr_en     = TABLE_WSTB && !TABLE_START && !wr_full;
    assign len_ok    = (TABLE_LENGTH != 16'd0) && (TABLE_LENGTH[1:0] == 2'b00) &&
                       (32'(TABLE_LENGTH) <= 32'(wptr_q));
    assign rst_acc   = frame_rst_i && ready_q;
    assign rd_acc    = frame_rd_i && valid_q && !frame_rst_i;
    assign index_inc = ({1'b0, index_q} == count_q - 1'b1) ? '0 : index_q + 1'b1;
    assign rd_addr   = {index_q, cnt_q[1:0]};

    // Storage has no reset so it maps onto block RAM with a registered read port.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr_q[AW-1:0]] <= TABLE_DATA;
        end
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            index_q <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= '{default: '0};
        end else begin
            // cnt_q 0..3 issues reads; 1..4 captures the word issued one cycle earlier.
            if (state_q == FETCH) begin
                if (cnt_q != 3'd0) begin
                    lane_q[cnt_q[1:0] - 2'd1] <= rd_data_q;
                end
                if (cnt_q == 3'd4) begin
                    state_q <= VALID;
                    valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                end
            end

            if (wr_en) begin
                wptr_q <= wptr_q + 1'b1;
            end else if (TABLE_WSTB && !TABLE_START) begin
                err_q <= 1'b1;
            end

            // Later assignments override the fetch progress above.
            if (TABLE_START) begin
                wptr_q  <= '0;
                ready_q <= 1'b0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                count_q <= '0;
                index_q <= '0;
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (TABLE_LENGTH_WSTB) begin
                index_q <= '0;
                valid_q <= 1'b0;
                cnt_q   <= '0;
                if (len_ok) begin
                    count_q <= TABLE_LENGTH[FW+2:2];
                    ready_q <= 1'b1;
                    state_q <= FETCH;
                end else begin
                    count_q <= '0;
                    ready_q <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end
            end else if (rst_acc) begin
                index_q <= '0;
                valid_q <= 1'b0;
                state_q <= FETCH;
                cnt_q   <= '0;
            end else if (rd_acc) begin
                index_q <= index_inc;
                valid_q <= 1'b0;
                state_q <= FETCH;
                cnt_q   <= '0;
            end
        end
    end

    assign frame_o       = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
    assign frame_valid_o = valid_q;
    assign frame_index_o = 16'(index_q);
    assign frame_count_o = 16'(count_q);
    assign table_ready_o = ready_q;
    assign wr_err_o      = err_q;

endmodule

// File: doc/panda_seq_table.md
PANDA_SEQ_TABLE -- requirements
Module: panda_seq_table

Interface
- REQ-001 SHALL have parameter DEPTH_FRAMES, default 256, maximum number of 4-word frames stored (1024 words).
- REQ-002 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
- REQ-003 SHALL have port reset_i, input, 1, reset; asynchronous, active-high.
- REQ-004 SHALL have port TABLE_START, input, 1, pulse that starts a new table load.
- REQ-005 SHALL have port TABLE_DATA, input, 32, table word to store.
- REQ-006 SHALL have port TABLE_WSTB, input, 1, one-cycle write strobe for TABLE_DATA.
- REQ-007 SHALL have port TABLE_LENGTH, input, 16, table length in words.
- REQ-008 SHALL have port TABLE_LENGTH_WSTB, input, 1, one-cycle strobe that commits TABLE_LENGTH.
- REQ-009 SHALL have port frame_rd_i, input, 1, consumer accepts current frame and requests the next.
- REQ-010 SHALL have port frame_rst_i, input, 1, consumer rewinds to frame 0.
- REQ-011 SHALL have port frame_o, output, 128, current frame; word0 in [31:0] through word3 in [127:96].
- REQ-012 SHALL have port frame_valid_o, output, 1, frame_o holds frame frame_index_o.
- REQ-013 SHALL have port frame_index_o, output, 16, index of frame in frame_o.
- REQ-014 SHALL have port frame_count_o, output, 16, number of frames in committed table.
- REQ-015 SHALL have port table_ready_o, output, 1, committed table available.
- REQ-016 SHALL have port wr_err_o, output, 1, sticky load error.

Function
- REQ-017 SHALL store words in a single-port-write, synchronous-read RAM of DEPTH_FRAMES*4 x 32.
- REQ-018 TABLE_START SHALL clear the write pointer, table_ready_o, frame_valid_o, wr_err_o, frame_count_o and frame_index_o, and abort any fetch, all on the sampling edge.
- REQ-019 TABLE_WSTB SHALL write TABLE_DATA at the write pointer and increment the pointer by 1.
- REQ-020 TABLE_WSTB with the pointer at DEPTH_FRAMES*4 SHALL discard the word and set wr_err_o.
- REQ-021 When TABLE_START and TABLE_WSTB occur in the same cycle, TABLE_START SHALL win and the word SHALL be discarded.
- REQ-022 TABLE_LENGTH_WSTB SHALL commit only if TABLE_LENGTH is nonzero, a multiple of 4, and no greater than the write pointer; frame_count_o=TABLE_LENGTH/4, table_ready_o=1, frame_index_o=0, start fetch.
- REQ-023 A rejected TABLE_LENGTH_WSTB SHALL set wr_err_o and leave table_ready_o=0 and frame_count_o=0.
- REQ-024 The fetch FSM SHALL have states IDLE, FETCH, VALID; IDLE->FETCH on commit/advance/rewind, FETCH->VALID after word3 is captured, VALID->FETCH on accepted frame_rd_i or frame_rst_i.
- REQ-025 FETCH SHALL issue word addresses index*4+0..3 on 4 consecutive cycles and capture each into its frame_o lane one cycle later.
- REQ-026 frame_valid_o SHALL rise on the 5th rising edge after the edge that commits, accepts frame_rd_i, or accepts frame_rst_i.
- REQ-027 frame_valid_o SHALL fall on the accepting edge itself.
- REQ-028 frame_rd_i SHALL be accepted only while frame_valid_o=1, and SHALL otherwise be ignored.
- REQ-029 On acceptance the index SHALL increment, wrapping from frame_count_o-1 to 0.
- REQ-030 frame_rst_i SHALL be accepted whenever table_ready_o=1, including during FETCH (restart), setting the index to 0.
- REQ-031 When frame_rst_i and frame_rd_i occur in the same cycle, frame_rst_i SHALL win.
- REQ-032 frame_o SHALL hold its value outside FETCH, and lanes SHALL change only in FETCH.
- REQ-033 TABLE_WSTB while table_ready_o=1 SHALL still write the RAM, without altering committed state; the writer SHALL reload via TABLE_START first.

Reset
- REQ-034 reset_i high SHALL asynchronously force frame_o=0, frame_valid_o=0, frame_index_o=0, frame_count_o=0, table_ready_o=0, wr_err_o=0, write pointer=0, FSM=IDLE.
- REQ-035 Reset SHALL leave RAM contents undefined.
- REQ-036 Reset asserted mid-fetch SHALL abort the fetch; after release the block SHALL idle until a new commit.

Verification
- REQ-037 Load and fetch: START, 8 words 0x1..0x8, LENGTH=8 -> table_ready_o=1, frame_count_o=2, valid 5 edges later, frame_o=0x00000004_00000003_00000002_00000001.
- REQ-038 Advance and wrap: frame_rd_i pulse -> index 1, frame_o words 0x5..0x8; a second pulse -> index 0, words 0x1..0x4, each with 5-edge latency.
- REQ-039 Bad length: 8 words, LENGTH=6 or LENGTH=12 -> wr_err_o=1, table_ready_o=0, frame_valid_o stays 0.
- REQ-040 Overflow: DEPTH_FRAMES=2, 9 words written -> wr_err_o=1, 9th word dropped; LENGTH=8 still commits.
- REQ-041 Simultaneous events: frame_rst_i and frame_rd_i together at index 1 -> index 0; frame_rd_i during FETCH -> ignored; frame_rst_i during FETCH -> fetch restarts at index 0.
- REQ-042 Async reset mid-fetch -> all outputs 0 immediately, no valid after release.
